imem_loader: RTL and testbench

//  Write-side companion to the instruction memory: accepts a byte stream and assembles it into

---
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Write-side companion to the instruction memory. Accepts a byte stream from
//   the host link and assembles it into little-endian 32-bit instruction words.
//   Each completed word is issued as a one-cycle write on the imem write port.
//   The core is held (o_cpu_hold) while a program is being loaded.
//
// Parameters:
//   DEPTH      number of 32-bit words in imem (power of two, >= 2)
//   BASE_ADDR  byte address of the first word written (word aligned)
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_reset      synchronous, active-high reset
//   i_start      one-cycle pulse: begin a load of i_num_words words
//   i_num_words  number of words to load, sampled only on an accepted start
//   i_s_valid    byte on i_s_data is valid
//   i_s_data     program byte; the first byte is instruction bits [7:0]
//   o_s_ready    loader accepts a byte this cycle (handshake = valid & ready)
//   o_mem_we     imem write enable, one cycle per word
//   o_mem_addr   byte address of the word being written ([1:0] always 0)
//   o_mem_wdata  assembled instruction word
//   o_cpu_hold   core must stall while high
//   o_busy       a load is in progress
//   o_done       last load completed; held until the next accepted start
//   o_err        one-cycle pulse: start rejected (word count 0 or > DEPTH)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [AW:0]   i_num_words,
  input  logic          i_s_valid,
  input  logic [7:0]    i_s_data,
  output logic          o_s_ready,
  output logic          o_mem_we,
  output logic [31:0]   o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic          o_cpu_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW + 1)'(1);

  state_t        r_state;
  logic [AW:0]   r_count;
  logic [AW:0]   r_word_idx;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_shift;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_done;
  logic          r_err;

  logic          w_loading;
  logic          w_num_ok;
  logic [31:0]   w_word_addr;

  assign w_loading = (r_state == ST_LOAD);
  assign w_num_ok  = (i_num_words != '0) && (i_num_words <= LP_DEPTH);

  // Only the low AW bits of the word index form the address; the index never
  // reaches DEPTH while a write is being issued, so the address stays in range.
  assign w_word_addr = BASE_ADDR + {{(30 - AW){1'b0}}, r_word_idx[AW-1:0], 2'b00};

  // Main control: state, byte assembly and the registered write port.
  // The first three bytes of a word are parked in r_shift; the fourth byte is
  // merged directly into the write data so the word is written the very next
  // cycle without stalling the byte stream.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            if (w_num_ok) begin
              r_state    <= ST_LOAD;
              r_count    <= i_num_words;
              r_word_idx <= '0;
              r_byte_cnt <= '0;
              r_done     <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // A start pulse here is deliberately ignored.
          if (i_s_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_shift[7:0]   <= i_s_data;
              2'd1: r_shift[15:8]  <= i_s_data;
              2'd2: r_shift[23:16] <= i_s_data;
              default: begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= {i_s_data, r_shift};
                r_mem_addr  <= w_word_addr;
                r_word_idx  <= r_word_idx + LP_ONE;
                if (r_word_idx == (r_count - LP_ONE)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
              end
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_s_ready   = w_loading;
  assign o_busy      = w_loading;
  // The final write happens the cycle after the state has left LOAD, so the
  // pending write keeps the core held until it has landed in imem.
  assign o_cpu_hold  = w_loading | r_mem_we;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Purpose:
//   Self-checking bench for imem_loader. A reference model turns each program
//   byte list into the expected (address, word) writes and queues them; an
//   independent monitor pops the queue on every write the loader issues.
//
// Ports: none (top-level testbench).
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] BASE  = 32'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   numWords;
  logic          sValid;
  logic [7:0]    sData;
  logic          sReady;
  logic          memWe;
  logic [31:0]   memAddr;
  logic [31:0]   memWdata;
  logic          cpuHold;
  logic          busy;
  logic          done;
  logic          err;

  int            checkCount = 0;
  int            passCount  = 0;
  int            weCount    = 0;
  logic [31:0]   lastAddr   = '0;
  logic [31:0]   expAddr[$];
  logic [31:0]   expData[$];
  logic [7:0]    progBytes[$];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_num_words (numWords),
    .i_s_valid   (sValid),
    .i_s_data    (sData),
    .o_s_ready   (sReady),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_cpu_hold  (cpuHold),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  // Inputs change on the falling edge so the loader samples them cleanly.
  task automatic applyStimulus(input logic st, input logic [AW:0] nw, input logic v, input logic [7:0] d);
    @(negedge clk);
    start    = st;
    numWords = nw;
    sValid   = v;
    sData    = d;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, 8'h00);
  endtask

  // Reference model: word i is bytes 4i..4i+3, little endian, at BASE + 4*i.
  task automatic modelLoad(input int nWords);
    for (int i = 0; i < nWords; i++) begin
      int unsigned w;
      w = int'(progBytes[4*i]) + (int'(progBytes[4*i+1]) * 256)
        + (int'(progBytes[4*i+2]) * 65536) + (int'(progBytes[4*i+3]) * 16777216);
      expAddr.push_back(BASE + 32'(4 * i));
      expData.push_back(w);
    end
  endtask

  task automatic randomBytes(input int n);
    progBytes.delete();
    for (int i = 0; i < n; i++) progBytes.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic startLoad(input logic [AW:0] nw);
    applyStimulus(1'b1, nw, 1'b0, 8'h00);
  endtask

  // Streams nBytes from progBytes with random idle gaps; pulses start alongside
  // byte startAt (negative for none) to show a mid-load start is ignored.
  task automatic sendProgram(input int nBytes, input int maxGap, input int startAt);
    for (int i = 0; i < nBytes; i++) begin
      int gap;
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      repeat (gap) applyStimulus(1'b0, '0, 1'b0, 8'h00);
      applyStimulus(i == startAt, 7'd2, 1'b1, progBytes[i]);
      if (startAt >= 0 && i == startAt + 1) checkOutput("err_midload", 32'(err), 32'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},    32'(busy),    32'd0);
    checkOutput({tag, "_done"},    32'(done),    32'd0);
    checkOutput({tag, "_err"},     32'(err),     32'd0);
    checkOutput({tag, "_we"},      32'(memWe),   32'd0);
    checkOutput({tag, "_hold"},    32'(cpuHold), 32'd0);
    checkOutput({tag, "_ready"},   32'(sReady),  32'd0);
    checkOutput({tag, "_addr"},    memAddr,      32'd0);
    checkOutput({tag, "_wdata"},   memWdata,     32'd0);
  endtask

  // Scoreboard monitor: every write must match the next expected write.
  always @(negedge clk) begin
    if (memWe === 1'b1) begin
      weCount++;
      lastAddr = memAddr;
      if (expAddr.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", memAddr, memWdata);
      end else begin
        checkOutput("wr_addr", memAddr,  expAddr.pop_front());
        checkOutput("wr_data", memWdata, expData.pop_front());
      end
    end
  end

  // Test sequence.
  initial begin
    int weBase;
    logic prevDone;

    reset = 1'b1; start = 1'b0; numWords = '0; sValid = 1'b0; sData = '0;

    // T1: reset with random activity on the inputs.
    $display("[TB] T1 reset");
    repeat (2) applyStimulus(1'($urandom_range(1, 0)), 7'($urandom_range(127, 0)),
                             1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
    applyStimulus(1'b0, '0, 1'b0, 8'h00);
    checkAllZero("t1");
    reset = 1'b0;
    idleCycles(1);

    // T2: two words back to back, with exact done/hold timing.
    $display("[TB] T2 two words back to back");
    progBytes = '{8'h37, 8'hA4, 8'h03, 8'h00, 8'h13, 8'h04, 8'h04, 8'h7D};
    weBase = weCount;
    modelLoad(2);
    startLoad(7'd2);
    applyStimulus(1'b0, '0, 1'b0, 8'h00);
    checkOutput("t2_busy",  32'(busy),    32'd1);
    checkOutput("t2_hold",  32'(cpuHold), 32'd1);
    checkOutput("t2_ready", 32'(sReady),  32'd1);
    checkOutput("t2_done0", 32'(done),    32'd0);
    sendProgram(8, 0, -1);
    applyStimulus(1'b0, '0, 1'b0, 8'h00);
    checkOutput("t2_we_last",   32'(memWe),   32'd1);
    checkOutput("t2_done_n1",   32'(done),    32'd1);
    checkOutput("t2_hold_n1",   32'(cpuHold), 32'd1);
    checkOutput("t2_ready_n1",  32'(sReady),  32'd0);
    applyStimulus(1'b0, '0, 1'b0, 8'h00);
    checkOutput("t2_done_n2",   32'(done),    32'd1);
    checkOutput("t2_hold_n2",   32'(cpuHold), 32'd0);
    idleCycles(2);
    checkOutput("t2_writes", 32'(weCount - weBase), 32'd2);
    checkOutput("t2_sb_empty", 32'(expAddr.size()), 32'd0);

    // T3: same program with random gaps between bytes.
    $display("[TB] T3 gapped stream");
    weBase = weCount;
    modelLoad(2);
    startLoad(7'd2);
    sendProgram(8, 5, -1);
    idleCycles(3);
    checkOutput("t3_writes", 32'(weCount - weBase), 32'd2);
    checkOutput("t3_done",   32'(done), 32'd1);
    checkOutput("t3_sb_empty", 32'(expAddr.size()), 32'd0);

    // T4: rejected starts.
    $display("[TB] T4 rejected starts");
    weBase = weCount;
    for (int k = 0; k < 2; k++) begin
      logic [AW:0] badNum;
      badNum = (k == 0) ? 7'd0 : 7'd65;
      prevDone = done;
      startLoad(badNum);
      applyStimulus(1'b0, '0, 1'b0, 8'h00);
      checkOutput("t4_err",  32'(err),  32'd1);
      checkOutput("t4_busy", 32'(busy), 32'd0);
      checkOutput("t4_done", 32'(done), 32'(prevDone));
      applyStimulus(1'b0, '0, 1'b0, 8'h00);
      checkOutput("t4_err_clear", 32'(err), 32'd0);
    end
    idleCycles(2);
    checkOutput("t4_writes", 32'(weCount - weBase), 32'd0);

    // Random programs, with bytes offered while DONE that must be refused.
    $display("[TB] random programs");
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(8, 1));
      randomBytes(4 * n);
      weBase = weCount;
      modelLoad(n);
      startLoad(7'(n));
      sendProgram(4 * n, 3, -1);
      idleCycles(2);
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b0, '0, 1'b1, 8'($urandom_range(255, 0)));
        checkOutput("rnd_ready_done", 32'(sReady), 32'd0);
      end
      idleCycles(2);
      checkOutput("rnd_writes", 32'(weCount - weBase), 32'(n));
      checkOutput("rnd_sb_empty", 32'(expAddr.size()), 32'd0);
    end

    // T5: reset in the middle of a load.
    $display("[TB] T5 reset mid-load");
    randomBytes(16);
    weBase = weCount;
    modelLoad(1);
    startLoad(7'd4);
    sendProgram(6, 0, -1);
    @(negedge clk);
    reset = 1'b1; sValid = 1'b0;
    @(negedge clk);
    checkAllZero("t5");
    reset = 1'b0;
    idleCycles(4);
    checkOutput("t5_writes", 32'(weCount - weBase), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_sb_empty", 32'(expAddr.size()), 32'd0);

    // T6: full-depth load with a start pulse in the middle.
    $display("[TB] T6 full depth");
    randomBytes(4 * DEPTH);
    weBase = weCount;
    modelLoad(DEPTH);
    startLoad(7'(DEPTH));
    sendProgram(4 * DEPTH, 0, 100);
    applyStimulus(1'b0, '0, 1'b0, 8'h00);
    checkOutput("t6_done", 32'(done), 32'd1);
    idleCycles(3);
    checkOutput("t6_writes", 32'(weCount - weBase), 32'(DEPTH));
    checkOutput("t6_last_addr", lastAddr, 32'h0000_00FC);
    checkOutput("t6_hold", 32'(cpuHold), 32'd0);
    checkOutput("t6_sb_empty", 32'(expAddr.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
